sub_arbiter: RTL and testbench
==============================

SUB_ARBITER -- requirements
Module: sub_arbiter

Interface
REQ-001 Parameter: DATAWIDTH, default 2, operand/result width in bits (legal range 1 to 32).
REQ-002 Clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Rst  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester request level; bit i belongs to requester i.
REQ-005 a  input  4*DATAWIDTH  minuends, flattened; requester i uses bits [i*DATAWIDTH +: DATAWIDTH].
REQ-006 b  input  4*DATAWIDTH  subtrahends, flattened with the same layout as a.
REQ-007 gnt  output  4  one-hot grant, held from the grant edge through the end of the CALC state.
REQ-008 done  output  4  one-hot, single-cycle result-valid pulse to the served requester.
REQ-009 diff  output  DATAWIDTH  registered result a-b for the served requester.
REQ-010 borrow  output  1  registered flag: 1 when a < b unsigned for the served operation.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and RESP.
REQ-013 IDLE SHALL move to CALC on any edge where req != 0, and SHALL otherwise stay in IDLE.
REQ-014 CALC SHALL move to RESP unconditionally.
REQ-015 RESP SHALL move to IDLE unconditionally.
REQ-016 The IDLE->CALC edge SHALL select a winner round-robin, latch that winner's a and b slices, and set gnt to the winner.
REQ-017 Round-robin search SHALL start at rr_ptr and increase modulo 4; the first set req bit wins.
REQ-018 rr_ptr SHALL become (winner+1) mod 4 on each grant and SHALL stay unchanged otherwise.
REQ-019 The CALC->RESP edge SHALL register diff = (a_lat - b_lat) mod 2^DATAWIDTH, register borrow, set done[winner]=1 and clear gnt.
REQ-020 The RESP->IDLE edge SHALL clear done, while diff and borrow SHALL hold their values until the next operation.
REQ-021 Latency from the request-sampling edge E to the done pulse SHALL be 2 cycles (done high during the cycle after E+1); throughput SHALL be one operation per 3 cycles.
REQ-022 Requests SHALL be ignored during CALC and RESP; req values present at those edges SHALL have no effect.
REQ-023 A requester SHALL drop req in its done cycle; a req still high in IDLE SHALL be treated as a new request.
REQ-024 Withdrawing req after grant SHALL NOT abort the operation; done SHALL still pulse.
REQ-025 Changes to a or b after the grant edge SHALL NOT affect the result.
REQ-026 Wrap-around example: with DATAWIDTH=2, 1-2 SHALL yield diff=3 and borrow=1; a==b SHALL yield diff=0 and borrow=0.
REQ-027 Simultaneous requests SHALL be served one per operation in round-robin order; no requester SHALL wait more than 3 operations while asserted.

Reset
REQ-028 While Rst=0: state=IDLE, rr_ptr=0, gnt=0, done=0, diff=0, borrow=0, busy=0, independent of Clk.
REQ-029 Reset asserted during CALC or RESP SHALL abandon the operation with no done pulse.
REQ-030 The first edge after Rst deasserts SHALL arbitrate normally.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2 bits: IDLE=0, CALC=1, RESP=2), the NREQ=4 constant and the rr_ptr width constant.
REQ-032 The subtraction SHALL be one instance of the component-library SUB module, with DATAWIDTH passed through, fed from the latched operands.
REQ-033 Round-robin winner selection SHALL be a combinational function inside sub_arbiter, not a separate module.

Verification (DATAWIDTH=8)
REQ-034 Single request: req=0001, a0=50, b0=20 -> gnt=0001 for 1 cycle, then done=0001, diff=30, borrow=0; busy high for 2 cycles.
REQ-035 Underflow: req=0100, a2=5, b2=9 -> done=0100, diff=252, borrow=1.
REQ-036 All four requesting continuously from reset -> grant order 0,1,2,3,0; done pulses spaced exactly 3 cycles apart.
REQ-037 Operand change: a1=100, b1=1 granted, then a1 changed to 0 during CALC -> diff=99.
REQ-038 Reset mid-op: Rst=0 during CALC -> all outputs 0 immediately, no done pulse; after release with req=1000 -> served first, rr_ptr becomes 0.
REQ-039 Early withdrawal: req3 dropped in CALC with a3=7, b3=7 -> done=1000, diff=0, borrow=0.

Source files
------------

// File: rtl/sub_arbiter_pkg.sv
// Shared definitions for the round-robin subtract arbiter: FSM encoding,
// requester count, round-robin pointer width and a one-hot helper.
package sub_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int PTR_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [PTR_W-1:0] ptr_t;

  // Turn a requester index into its one-hot grant/done vector.
  function automatic logic [NREQ-1:0] onehot(input ptr_t idx);
    logic [NREQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/SUB.sv
// Component-library subtractor: diff = a - b modulo 2^DATAWIDTH, and
// borrow = 1 when a < b (unsigned).
module SUB #(
  parameter int DATAWIDTH = 2
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] diff,
  output logic                 borrow
);

  // One extra bit on the left catches the borrow out of the subtraction.
  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/sub_arbiter.sv
// Four requesters share one subtractor. A round-robin pick in IDLE grants one
// requester and latches its operands; CALC registers the result and pulses
// done in RESP. One operation every three cycles.
module sub_arbiter
  import sub_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATAWIDTH-1:0] a,
  input  logic [NREQ*DATAWIDTH-1:0] b,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [DATAWIDTH-1:0]      diff,
  output logic                      borrow,
  output logic                      busy
);

  state_t                 state, state_nxt;
  ptr_t                   rr_ptr;
  ptr_t                   win;
  logic [DATAWIDTH-1:0]   a_lat, b_lat;
  logic [DATAWIDTH-1:0]   sub_diff;
  logic                   sub_borrow;
  logic [PTR_W:0]         pick;
  logic                   found;
  ptr_t                   pick_idx;

  // First set request bit at or after ptr, wrapping modulo NREQ. Returns
  // {found, index}. Scanning from the farthest offset back means the nearest
  // offset is the last assignment and therefore wins.
  function automatic logic [PTR_W:0] rr_pick(input logic [NREQ-1:0] r,
                                             input ptr_t ptr);
    logic [PTR_W:0] res;
    ptr_t           idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + ptr_t'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign pick     = rr_pick(req, rr_ptr);
  assign found    = pick[PTR_W];
  assign pick_idx = pick[PTR_W-1:0];
  assign busy     = (state != IDLE);

  SUB #(
    .DATAWIDTH(DATAWIDTH)
  ) u_sub (
    .a      (a_lat),
    .b      (b_lat),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; requests only matter in IDLE.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: grant and operand capture, result registration, done pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rr_ptr <= '0;
      win    <= '0;
      a_lat  <= '0;
      b_lat  <= '0;
      gnt    <= '0;
      done   <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            win    <= pick_idx;
            a_lat  <= a[pick_idx*DATAWIDTH +: DATAWIDTH];
            b_lat  <= b[pick_idx*DATAWIDTH +: DATAWIDTH];
            gnt    <= onehot(pick_idx);
            rr_ptr <= pick_idx + ptr_t'(1);
          end
        end
        CALC: begin
          diff   <= sub_diff;
          borrow <= sub_borrow;
          done   <= onehot(win);
          gnt    <= '0;
        end
        RESP: begin
          done <= '0;
        end
        default: begin
          gnt  <= '0;
          done <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_arbiter.sv
// Self-checking bench for sub_arbiter with DATAWIDTH=8: directed scenarios
// with hand-computed values, then randomized traffic against a behavioural
// model that is compared on every cycle out of reset.
module tb_sub_arbiter;

  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [3:0]    req;
  logic [4*DW-1:0] a, b;
  logic [3:0]    gnt, done;
  logic [DW-1:0] diff;
  logic          borrow, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  sub_arbiter #(.DATAWIDTH(DW)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .req    (req),
    .a      (a),
    .b      (b),
    .gnt    (gnt),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .busy   (busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 computing, 2 responding.
  int          m_phase, m_ptr, m_win;
  logic [DW-1:0] m_a, m_b, m_diff;
  logic        m_borrow;
  logic [3:0]  m_gnt, m_done;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_phase = 0; m_ptr = 0; m_win = 0; m_a = 0; m_b = 0;
      m_diff = 0; m_borrow = 0; m_gnt = 0; m_done = 0;
    end else begin
      case (m_phase)
        0: begin
          if (req != 4'b0) begin
            for (int k = 3; k >= 0; k--)
              if (req[(m_ptr + k) % 4]) m_win = (m_ptr + k) % 4;
            m_a     = a[m_win*DW +: DW];
            m_b     = b[m_win*DW +: DW];
            m_gnt   = 4'(1 << m_win);
            m_ptr   = (m_win + 1) % 4;
            m_phase = 1;
          end
        end
        1: begin
          m_diff   = DW'((int'(m_a) - int'(m_b) + 256) % 256);
          m_borrow = (m_a < m_b);
          m_done   = 4'(1 << m_win);
          m_gnt    = 0;
          m_phase  = 2;
        end
        default: begin
          m_done  = 0;
          m_phase = 0;
        end
      endcase
    end
  end

  // Compare DUT against the model 1 ns after every rising edge out of reset.
  always @(posedge Clk) begin
    #1;
    if (Rst === 1'b1) begin
      check("model_gnt",    gnt,    m_gnt);
      check("model_done",   done,   m_done);
      check("model_diff",   diff,   m_diff);
      check("model_borrow", borrow, m_borrow);
      check("model_busy",   busy,   m_phase != 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_op(input int i, input int av, input int bv);
    a[i*DW +: DW] = DW'(av);
    b[i*DW +: DW] = DW'(bv);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},    gnt,    0);
    check({tag, "_done"},   done,   0);
    check({tag, "_diff"},   diff,   0);
    check({tag, "_borrow"}, borrow, 0);
    check({tag, "_busy"},   busy,   0);
  endtask

  int done_cyc[$];
  int done_who[$];

  initial begin
    Rst = 1'b0; req = '0; a = '0; b = '0;
    #3;
    check_zero("reset");
    tick();
    Rst = 1'b1;
    tick();

    // Single request, no underflow.
    req = 4'b0001; set_op(0, 50, 20);
    tick();
    check("single_gnt", gnt, 4'b0001);
    check("single_busy1", busy, 1);
    req = 4'b0000;
    tick();
    check("single_done", done, 4'b0001);
    check("single_diff", diff, 30);
    check("single_borrow", borrow, 0);
    check("single_gnt_clr", gnt, 0);
    check("single_busy2", busy, 1);
    tick();
    check("single_done_clr", done, 0);
    check("single_busy_off", busy, 0);
    check("single_diff_hold", diff, 30);

    // Underflow on requester 2.
    req = 4'b0100; set_op(2, 5, 9);
    tick();
    check("under_gnt", gnt, 4'b0100);
    req = 4'b0000;
    tick();
    check("under_done", done, 4'b0100);
    check("under_diff", diff, 252);
    check("under_borrow", borrow, 1);
    tick();

    // Operand change after grant must not matter.
    req = 4'b0010; set_op(1, 100, 1);
    tick();
    check("opchg_gnt", gnt, 4'b0010);
    set_op(1, 0, 1);
    req = 4'b0000;
    tick();
    check("opchg_diff", diff, 99);
    check("opchg_borrow", borrow, 0);
    tick();

    // Early withdrawal of req3 in CALC.
    req = 4'b1000; set_op(3, 7, 7);
    tick();
    check("wd_gnt", gnt, 4'b1000);
    req = 4'b0000;
    tick();
    check("wd_done", done, 4'b1000);
    check("wd_diff", diff, 0);
    check("wd_borrow", borrow, 0);
    tick();

    // Reset during CALC abandons the op; all outputs clear immediately.
    req = 4'b0001; set_op(0, 3, 1);
    tick();
    check("rst_pre_gnt", gnt, 4'b0001);
    req = 4'b0000;
    #2 Rst = 1'b0;
    #1;
    check_zero("rst_mid");
    tick();
    check_zero("rst_held");
    req = 4'b1000; set_op(3, 9, 4);
    Rst = 1'b1;
    tick();
    check("rst_after_gnt", gnt, 4'b1000);
    req = 4'b0000;
    tick();
    check("rst_after_done", done, 4'b1000);
    check("rst_after_diff", diff, 5);
    tick();
    // rr_ptr wrapped to 0, so requester 0 wins among all four.
    req = 4'b1111;
    tick();
    check("rst_ptr0_gnt", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    tick();

    // All four requesting continuously from reset.
    #2 Rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_op(i, 10 * (i + 1), i);
    #2 Rst = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done != 4'b0) begin
        done_cyc.push_back(c);
        for (int i = 0; i < 4; i++) if (done[i]) done_who.push_back(i);
      end
    end
    req = 4'b0000;
    check("rr_count", done_who.size(), 5);
    if (done_who.size() == 5) begin
      check("rr_w0", done_who[0], 0);
      check("rr_w1", done_who[1], 1);
      check("rr_w2", done_who[2], 2);
      check("rr_w3", done_who[3], 3);
      check("rr_w4", done_who[4], 0);
      for (int i = 1; i < 5; i++)
        check("rr_spacing", done_cyc[i] - done_cyc[i-1], 3);
    end
    tick();
    tick();

    // Randomized traffic, checked every cycle by the model comparator.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 20) == 0) set_op($urandom_range(0, 3), 255, 255);
      if ($urandom_range(0, 79) == 0) begin
        #2 Rst = 1'b0;
        #2 Rst = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
